// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
// Spawns enemies into the forward/left/right slots on an LFSR-driven schedule,
// times each enemy's attack and resolves kills from weapon fire edges.
// All timing advances on the one-cycle `tick` strobe; logic runs on `clk`.
// Optional feature: define ENEMY_DIFFICULTY_RAMP_EN to shorten the spawn
// interval as the kill count grows (floored at a quarter of SPAWN_TICKS).
// Slot bit order inside this module: bit0 = forward, bit1 = left, bit2 = right.

module enemy_spawn_scheduler #(
    parameter int unsigned SPAWN_TICKS  = 150,
    parameter int unsigned ATTACK_TICKS = 300,
    parameter int unsigned LIVES        = 3,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] camera_view,
    input  logic [2:0] fire_state,
    output logic [2:0] enemy_state,
    output logic       forward_enemy_flag,
    output logic       left_enemy_flag,
    output logic       right_enemy_flag,
    output logic       enemy_attack,
    output logic [1:0] lives,
    output logic [7:0] kill_count
);

    localparam int unsigned     ATK_W      = (ATTACK_TICKS < 1) ? 1 : $clog2(ATTACK_TICKS + 1);
    localparam logic [ATK_W-1:0] ATK_MAX   = ATK_W'(ATTACK_TICKS);
    localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
    localparam logic [15:0]     SPAWN_THR  = (SPAWN_TICKS < 1) ? 16'd1 : 16'(SPAWN_TICKS);
    localparam logic [2:0]      FIRE_CODE  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_OVER = 3'b100
    } state_t;

    // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Camera direction code to one-hot slot; intermediate codes select nothing
    function automatic logic [2:0] decode_view(input logic [2:0] cam);
        logic [2:0] sel;
        case (cam)
            3'b001:  sel = 3'b001;
            3'b011:  sel = 3'b010;
            3'b110:  sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    // Preferred slot if free, otherwise next free slot walking F->L->R->F
    function automatic logic [2:0] pick_slot(input logic [1:0] pref, input logic [2:0] occ);
        logic [2:0] sel;
        case (pref)
            2'b01:   sel = !occ[1] ? 3'b010 : (!occ[2] ? 3'b100 : (!occ[0] ? 3'b001 : 3'b000));
            2'b10:   sel = !occ[2] ? 3'b100 : (!occ[0] ? 3'b001 : (!occ[1] ? 3'b010 : 3'b000));
            default: sel = !occ[0] ? 3'b001 : (!occ[1] ? 3'b010 : (!occ[2] ? 3'b100 : 3'b000));
        endcase
        return sel;
    endfunction

    // Fixed priority F > L > R, one grant at most
    function automatic logic [2:0] prio_pick(input logic [2:0] req);
        logic [2:0] gnt;
        if (req[0]) begin
            gnt = 3'b001;
        end else if (req[1]) begin
            gnt = 3'b010;
        end else if (req[2]) begin
            gnt = 3'b100;
        end else begin
            gnt = 3'b000;
        end
        return gnt;
    endfunction

    // Attack timer: load on spawn, count ticks while occupied, hold at the limit
    function automatic logic [ATK_W-1:0] timer_next(input logic [ATK_W-1:0] cur, input logic occ,
                                                    input logic load, input logic adv);
        logic [ATK_W-1:0] nx;
        if (load) begin
            nx = {ATK_W{1'b0}};
        end else if (occ && adv && (cur != ATK_MAX)) begin
            nx = cur + 1'b1;
        end else begin
            nx = cur;
        end
        return nx;
    endfunction

    state_t           state_r, state_nx_s;
    logic [2:0]       slot_r, slot_nx_s;
    logic [ATK_W-1:0] atk_fwd_r, atk_lft_r, atk_rgt_r;
    logic [ATK_W-1:0] atk_fwd_nx_s, atk_lft_nx_s, atk_rgt_nx_s;
    logic [1:0]       lives_r, lives_nx_s;
    logic [7:0]       kill_r, kill_nx_s;
    logic             attack_r, attack_nx_s;
    logic [7:0]       lfsr_r, lfsr_nx_s;
    logic [15:0]      spawn_cnt_r, spawn_cnt_nx_s;
    logic [2:0]       fire_prev_r;

    logic             run_s;
    logic             tick_run_s;
    logic             fire_edge_s;
    logic [2:0]       kill_s;
    logic [2:0]       atk_full_s;
    logic [2:0]       svc_s;
    logic [15:0]      thr_s;
    logic             spawn_wrap_s;
    logic [2:0]       spawn_s;

    assign run_s       = (state_r == ST_RUN);
    assign tick_run_s  = run_s && tick;
    assign fire_edge_s = (fire_state == FIRE_CODE) && (fire_prev_r != FIRE_CODE);
    assign kill_s      = (run_s && fire_edge_s) ? (decode_view(camera_view) & slot_r) : 3'b000;
    assign atk_full_s  = {atk_rgt_r == ATK_MAX, atk_lft_r == ATK_MAX, atk_fwd_r == ATK_MAX};
    // A slot killed this cycle is never serviced as an attack
    assign svc_s       = run_s ? prio_pick(slot_r & atk_full_s & ~kill_s) : 3'b000;

`ifdef ENEMY_DIFFICULTY_RAMP_EN
    localparam logic [15:0] RAMP_FLOOR = ((SPAWN_THR >> 2) < 16'd1) ? 16'd1 : (SPAWN_THR >> 2);
    logic [15:0] ramp_dec_s;

    // Interval shrinks by 8 ticks per 4 kills, never below the floor
    always_comb begin
        ramp_dec_s = {7'd0, kill_r[7:2], 3'b000};
        if ({1'b0, SPAWN_THR} > ({1'b0, ramp_dec_s} + {1'b0, RAMP_FLOOR})) begin
            thr_s = SPAWN_THR - ramp_dec_s;
        end else begin
            thr_s = RAMP_FLOOR;
        end
    end
`else
    assign thr_s = SPAWN_THR;
`endif

    // >= so a threshold that drops below the running count still wraps
    assign spawn_wrap_s = spawn_cnt_r >= (thr_s - 16'd1);
    // Spawn target is chosen from occupancy before any same-cycle clear
    assign spawn_s      = (tick_run_s && spawn_wrap_s) ? pick_slot(lfsr_r[1:0], slot_r) : 3'b000;

    // Next-state and datapath update for the IDLE/RUN/OVER game FSM
    always_comb begin
        state_nx_s     = state_r;
        slot_nx_s      = slot_r;
        atk_fwd_nx_s   = atk_fwd_r;
        atk_lft_nx_s   = atk_lft_r;
        atk_rgt_nx_s   = atk_rgt_r;
        lives_nx_s     = lives_r;
        kill_nx_s      = kill_r;
        attack_nx_s    = 1'b0;
        lfsr_nx_s      = lfsr_r;
        spawn_cnt_nx_s = spawn_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s     = ST_RUN;
                    lives_nx_s     = LIVES_INIT;
                    kill_nx_s      = 8'd0;
                    spawn_cnt_nx_s = 16'd0;
                    slot_nx_s      = 3'b000;
                    atk_fwd_nx_s   = {ATK_W{1'b0}};
                    atk_lft_nx_s   = {ATK_W{1'b0}};
                    atk_rgt_nx_s   = {ATK_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                slot_nx_s    = (slot_r & ~kill_s & ~svc_s) | spawn_s;
                atk_fwd_nx_s = timer_next(atk_fwd_r, slot_r[0], spawn_s[0], tick);
                atk_lft_nx_s = timer_next(atk_lft_r, slot_r[1], spawn_s[1], tick);
                atk_rgt_nx_s = timer_next(atk_rgt_r, slot_r[2], spawn_s[2], tick);
                if (tick) begin
                    lfsr_nx_s      = lfsr_next(lfsr_r);
                    spawn_cnt_nx_s = spawn_wrap_s ? 16'd0 : (spawn_cnt_r + 16'd1);
                end else begin
                    lfsr_nx_s      = lfsr_r;
                    spawn_cnt_nx_s = spawn_cnt_r;
                end
                if ((kill_s != 3'b000) && (kill_r != 8'hFF)) begin
                    kill_nx_s = kill_r + 8'd1;
                end else begin
                    kill_nx_s = kill_r;
                end
                if (svc_s != 3'b000) begin
                    attack_nx_s = 1'b1;
                    lives_nx_s  = lives_r - 2'd1;
                    if (lives_r <= 2'd1) begin
                        state_nx_s = ST_OVER;
                        slot_nx_s  = 3'b000;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    attack_nx_s = 1'b0;
                end
            end
            ST_OVER: begin
                if (!start) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OVER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; every output comes straight from here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            slot_r      <= 3'b000;
            atk_fwd_r   <= {ATK_W{1'b0}};
            atk_lft_r   <= {ATK_W{1'b0}};
            atk_rgt_r   <= {ATK_W{1'b0}};
            lives_r     <= LIVES_INIT;
            kill_r      <= 8'd0;
            attack_r    <= 1'b0;
            lfsr_r      <= LFSR_SEED;
            spawn_cnt_r <= 16'd0;
            fire_prev_r <= 3'b000;
        end else begin
            state_r     <= state_nx_s;
            slot_r      <= slot_nx_s;
            atk_fwd_r   <= atk_fwd_nx_s;
            atk_lft_r   <= atk_lft_nx_s;
            atk_rgt_r   <= atk_rgt_nx_s;
            lives_r     <= lives_nx_s;
            kill_r      <= kill_nx_s;
            attack_r    <= attack_nx_s;
            lfsr_r      <= lfsr_nx_s;
            spawn_cnt_r <= spawn_cnt_nx_s;
            fire_prev_r <= fire_state;
        end
    end

    assign enemy_state        = state_r;
    assign forward_enemy_flag = slot_r[0];
    assign left_enemy_flag    = slot_r[1];
    assign right_enemy_flag   = slot_r[2];
    assign enemy_attack       = attack_r;
    assign lives              = lives_r;
    assign kill_count         = kill_r;

endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Sequences enemy activity for the three view directions (forward, left, right): it spawns enemies into free slots on a pseudo-random schedule, times each enemy's attack, and resolves kills. It sits between `weapon_controller` and `camera_controller` on one side and the SSD/rendering logic on the other. It replaces the free-running spawn logic inside `enemy_controller`. All timing advances on a one-cycle `tick` strobe (~100 Hz) while logic runs on the system clock.

## Interface

**Parameters**
- `SPAWN_TICKS`, default 150: ticks between spawn attempts.
- `ATTACK_TICKS`, default 300: ticks an enemy lives before attacking.
- `LIVES`, default 3: lives loaded on game start (1–3).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be non-zero.

**Ports**
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk`-wide timing strobe.
- `start` in 1: level; game-run request.
- `camera_view` in 3: direction code. 3'b001 = F, 3'b011 = L, 3'b110 = R; any other value is intermediate (no direction).
- `fire_state` in 3: weapon state. 3'b010 = firing.
- `enemy_state` out 3: one-hot FSM state. 3'b001 = IDLE, 3'b010 = RUN, 3'b100 = OVER.
- `forward_enemy_flag`, `left_enemy_flag`, `right_enemy_flag` out 1 each: slot occupied.
- `enemy_attack` out 1: one-cycle pulse per serviced attack.
- `lives` out 2: remaining lives.
- `kill_count` out 8: kills, saturating at 255.

## Operation

- **Reset** (`rst_n` = 0): `enemy_state` = IDLE; all flags = 0; `enemy_attack` = 0; `lives` = `LIVES`; `kill_count` = 0; all timers = 0; LFSR = `LFSR_SEED`.
- **IDLE → RUN** when `start` = 1. On entry: reload `lives` = `LIVES`, clear `kill_count`, spawn timer and slots.
- **RUN → OVER** on the cycle `lives` reaches 0. On entry all flags clear. Timers freeze.
- **OVER → IDLE** when `start` = 0.
- **LFSR**: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Advances on every `tick` in RUN.
- **Spawn**
  - The spawn timer increments on `tick` in RUN.
  - On the tick where it reaches threshold−1, it wraps to 0 and a spawn attempt occurs.
  - Preferred slot = LFSR[1:0]: 00 = F, 01 = L, 10 = R, 11 = F.
  - If the preferred slot is occupied, take the next free slot in order F→L→R→F. If all three are occupied, the attempt is dropped.
  - A spawned slot's attack timer loads 0.
  - Spawn uses occupancy before same-cycle clears.
- **Attack**
  - Each occupied slot's timer increments on `tick` and saturates at `ATTACK_TICKS`.
  - Slots at `ATTACK_TICKS` are serviced one per `clk`, priority F > L > R; unserviced slots hold.
  - Service clears the slot, pulses `enemy_attack`, and decrements `lives`.
- **Kill**
  - A fire edge is `fire_state` == 3'b010 this cycle and != 3'b010 the previous cycle (registered copy; reset value 0).
  - On a fire edge, if `camera_view` decodes to an occupied slot, that slot clears and `kill_count` increments (saturating).
  - No effect outside RUN or when `camera_view` is intermediate.
  - Kill beats attack on the same slot in the same cycle: no attack pulse, `lives` unchanged.
- **Mid-operation inputs**
  - `start` falling during RUN has no effect.
  - Async reset at any point returns all state to reset values immediately.

## Timing

- All outputs are registered.
- Flag set or clear and `enemy_attack` become visible on the `clk` edge after the qualifying condition, giving 1-cycle latency.
- `enemy_attack` is high for exactly one `clk` per serviced slot.
- Simultaneous attacks on F and L produce pulses on consecutive cycles.
- `lives` decrements on the same edge that raises `enemy_attack`.
- `enemy_state` changes one edge after its transition condition.

## Configuration

- **`ENEMY_DIFFICULTY_RAMP_EN` defined**: spawn threshold = max(`SPAWN_TICKS` − 8·(`kill_count`>>2), `SPAWN_TICKS`>>2), recomputed combinationally each wrap.
- **Not defined**: threshold is fixed at `SPAWN_TICKS`; `kill_count` has no effect on scheduling.

## Test plan

- **Reset and start**: reset, then `start` = 1 with `SPAWN_TICKS` = 4 and seed 8'hA5 → `enemy_state` 001→010 one edge later. First spawn on the 4th tick into the slot given by LFSR[1:0]. All other outputs at reset values until then.
- **Occupancy fallback**: `SPAWN_TICKS` = 1, hold `camera_view` = 0, 3 ticks → all three flags set. Further spawn ticks change nothing.
- **Attack**: `ATTACK_TICKS` = 5, one enemy spawned F → `enemy_attack` is a single 1-cycle pulse after its 5th tick. F flag clears and `lives` goes 3→2 on the same edge.
- **Priority**: F and L reach `ATTACK_TICKS` on the same tick → two pulses on consecutive `clk` cycles, F first. `lives` drops by 2.
- **Kill and race**
  - With L occupied, `camera_view` = 011 and `fire_state` 001→010 → L clears next edge, `kill_count` = 1.
  - Holding 010 does not kill a newly spawned L enemy.
  - A fire edge on the same cycle L hits `ATTACK_TICKS` → kill, no attack pulse.
- **Game over**: 3 unanswered attacks → `enemy_state` = 100 and flags cleared. `start` = 0 → IDLE. With `ENEMY_DIFFICULTY_RAMP_EN`, `SPAWN_TICKS` = 40 and 4 kills → interval 32 ticks.
